// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the RV32I fetch stage.
package riscv_pkg;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        trap;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response port of the fetch stage.
//
// Handshake: a request transfers on a rising clock edge where req and ready
// are both high; addr must be stable while req is high. The response is a
// single-cycle rvalid pulse carrying rdata, at least one cycle after the
// request transfers. Only one request is ever outstanding, so responses are
// matched to requests by order alone.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rvalid, input rdata);
  modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding buffer for a response that arrives while the
// output slot is occupied and stalled. Clear wins over load, load over drain.
module fetch_skid
  import riscv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  fetch_slot_t i_data,
  output logic        o_valid,
  output fetch_slot_t o_data
);

  logic        r_valid;
  fetch_slot_t r_data;

  // Hold one entry; flush on clear, capture on load, release on drain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage. Keeps the PC, issues one
// word-aligned request at a time, and presents {instr, pc, pc+4} to decode.
// Optional build macro: FETCH_PERF_EN adds o_fetch_count / o_stall_cycles.
module fetch_unit
  import riscv_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  fetch_unit_if.master imem,
  input  logic         i_redirect,
  input  logic [31:0]  i_redirect_pc,
  input  logic         i_stall,
  output logic         o_valid,
  output logic [31:0]  o_instruction,
  output logic [31:0]  o_pc,
  output logic [31:0]  o_pc_plus4,
  output logic         o_fetch_trap,
  output fetch_state_t o_dbg_state,
  output logic         o_dbg_squash
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  o_fetch_count,
  output logic [31:0]  o_stall_cycles
`endif
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]  r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic [31:0] r_req_pc, w_req_pc_nx;
  logic        r_squash, w_squash_nx;
  logic        r_valid, w_valid_nx;
  fetch_slot_t r_slot, w_slot_nx;
  fetch_slot_t w_resp_slot, w_skid_data;
  logic        w_skid_load, w_skid_drain, w_skid_clear, w_skid_valid;
  logic        w_consume, w_inflight, w_misaligned;

  assign w_consume    = r_valid & ~i_stall;
  assign w_misaligned = (i_redirect_pc[1:0] != 2'b00);
  // A response is still owed by memory if we are waiting without it, a request
  // transfers this very cycle, or an earlier squashed one has not come back.
  assign w_inflight   = ((r_state == ST_WAIT) & ~imem.rvalid)
                      | ((r_state == ST_REQ) & imem.ready)
                      | (r_squash & ~imem.rvalid);
  assign w_resp_slot  = '{instr: imem.rdata, pc: r_req_pc, trap: 1'b0};

  fetch_skid u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_clear (w_skid_clear),
    .i_data  (w_resp_slot),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  // Next-state logic: redirect overrides everything, otherwise the FSM steps.
  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_pc;
    w_req_pc_nx  = r_req_pc;
    w_squash_nx  = r_squash;
    w_valid_nx   = r_valid & ~w_consume;
    w_slot_nx    = r_slot;
    w_skid_load  = 1'b0;
    w_skid_drain = 1'b0;
    w_skid_clear = 1'b0;
    if (i_redirect) begin
      w_pc_nx      = i_redirect_pc;
      w_valid_nx   = 1'b0;
      w_skid_clear = 1'b1;
      if (w_misaligned) begin
        // Park in HOLD with an empty skid: that combination is the trap flag.
        w_state_nx  = ST_HOLD;
        w_squash_nx = w_inflight;
        w_valid_nx  = 1'b1;
        w_slot_nx   = '{instr: NOP, pc: i_redirect_pc, trap: 1'b1};
      end else if (w_inflight) begin
        w_state_nx  = ST_WAIT;
        w_squash_nx = 1'b1;
      end else begin
        w_state_nx  = ST_REQ;
        w_squash_nx = 1'b0;
      end
    end else begin
      case (r_state)
        ST_BOOT: w_state_nx = ST_REQ;
        ST_REQ: begin
          if (imem.ready) begin
            w_req_pc_nx = r_pc;
            w_pc_nx     = r_pc + 32'd4;
            w_state_nx  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem.rvalid) begin
            if (r_squash) begin
              w_squash_nx = 1'b0;
              w_state_nx  = ST_REQ;
            end else if (~r_valid | ~i_stall) begin
              w_valid_nx = 1'b1;
              w_slot_nx  = w_resp_slot;
              w_state_nx = ST_REQ;
            end else begin
              w_skid_load = 1'b1;
              w_state_nx  = ST_HOLD;
            end
          end
        end
        default: begin
          if (w_skid_valid) begin
            if (~i_stall) begin
              w_valid_nx   = 1'b1;
              w_slot_nx    = w_skid_data;
              w_skid_drain = 1'b1;
              w_state_nx   = ST_REQ;
            end
          end else if (imem.rvalid) begin
            // Trap park: a response owed from before the redirect is discarded.
            w_squash_nx = 1'b0;
          end
        end
      endcase
    end
  end

  // Register FSM, PC and output slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_BOOT;
      r_pc     <= RESET_ADDR;
      r_req_pc <= RESET_ADDR;
      r_squash <= 1'b0;
      r_valid  <= 1'b0;
      r_slot   <= '{instr: NOP, pc: RESET_ADDR, trap: 1'b0};
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_req_pc <= w_req_pc_nx;
      r_squash <= w_squash_nx;
      r_valid  <= w_valid_nx;
      r_slot   <= w_slot_nx;
    end
  end

  // Memory request comes from registered state only.
  assign imem.req      = (r_state == ST_REQ);
  assign imem.addr     = {r_pc[31:2], 2'b00};

  assign o_valid       = r_valid;
  assign o_instruction = (r_valid & ~r_slot.trap) ? r_slot.instr : NOP;
  assign o_pc          = r_slot.pc;
  assign o_pc_plus4    = r_slot.pc + 32'd4;
  assign o_fetch_trap  = r_valid & r_slot.trap;
  assign o_dbg_state   = fetch_state_t'(r_state);
  assign o_dbg_squash  = r_squash;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count, r_stall_cycles;

  // Count slot consumptions and stalled-occupied cycles; both wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_count  <= 32'd0;
      r_stall_cycles <= 32'd0;
    end else begin
      if (w_consume)          r_fetch_count  <= r_fetch_count + 32'd1;
      if (r_valid & i_stall)  r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_fetch_count  = r_fetch_count;
  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a latency-programmable
// memory responder and an acceptance-ordered scoreboard.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic         clk;
  logic         rst;
  logic         i_redirect;
  logic [31:0]  i_redirect_pc;
  logic         i_stall;
  logic         o_valid;
  logic [31:0]  o_instruction;
  logic [31:0]  o_pc;
  logic [31:0]  o_pc_plus4;
  logic         o_fetch_trap;
  fetch_state_t o_dbg_state;
  logic         o_dbg_squash;
`ifdef FETCH_PERF_EN
  logic [31:0]  o_fetch_count;
  logic [31:0]  o_stall_cycles;
`endif

  fetch_unit_if imem ();

  fetch_unit dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .imem          (imem),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_stall       (i_stall),
    .o_valid       (o_valid),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4),
    .o_fetch_trap  (o_fetch_trap),
    .o_dbg_state   (o_dbg_state),
    .o_dbg_squash  (o_dbg_squash)
`ifdef FETCH_PERF_EN
    ,
    .o_fetch_count (o_fetch_count),
    .o_stall_cycles(o_stall_cycles)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int n_pops = 0;
  int mem_lat = 0;
  logic [64:0] exp_q[$];

  typedef struct {
    logic [31:0] target;
    logic        req;
    logic        valid;
    logic        trap;
    logic [31:0] pc4;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out, got no event expected one within 50 cycles", name);
  endtask

  // ---------------- driver / responder ----------------
  task automatic responder();
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    pend = 1'b0;
    paddr = '0;
    cnt = 0;
    imem.rvalid = 1'b0;
    imem.rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && imem.req && imem.ready) begin
        pend = 1'b1;
        paddr = imem.addr;
        cnt = mem_lat;
      end
      @(posedge clk);
      #1;
      imem.rvalid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem.rvalid = 1'b1;
          imem.rdata = mem_word(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic sb_monitor();
    logic [64:0] e;
    logic [31:0] epc4;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (o_valid && !i_stall) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_unexpected: got slot pc %0h expected no output", o_pc);
          end else begin
            e = exp_q.pop_front();
            n_pops++;
            epc4 = e[64:33] + 32'd4;
            check("sb_pc", o_pc, e[64:33]);
            check("sb_instr", o_instruction, e[32:1]);
            check("sb_pc4", o_pc_plus4, epc4);
            check("sb_trap", o_fetch_trap, e[0]);
          end
        end
        if (imem.req && imem.ready)
          exp_q.push_back({imem.addr, mem_word(imem.addr), 1'b0});
        if (i_redirect) begin
          exp_q.delete();
          if (i_redirect_pc[1:0] != 2'b00)
            exp_q.push_back({i_redirect_pc, NOP, 1'b1});
        end
      end
    end
  endtask

  task automatic wait_accept(input string name, input logic [31:0] exp_addr);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (imem.req && imem.ready) break;
    end
    if (k == 50) timeout(name);
    else check(name, imem.addr, exp_addr);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_valid) break;
    end
    if (k == 50) timeout(name);
    else check(name, o_pc, exp_pc);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    int hold_cycles;
    int req_in_hold;

    tbl[0] = '{32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0104};
    tbl[1] = '{32'h0000_0102, 1'b0, 1'b1, 1'b1, 32'h0000_0106};
    tbl[2] = '{32'h0000_0203, 1'b0, 1'b1, 1'b1, 32'h0000_0207};
    tbl[3] = '{32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h8000_0004};
    tbl[4] = '{32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h0000_0005};
    tbl[5] = '{32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0000_0000};

    rst = 1'b1;
    i_redirect = 1'b0;
    i_redirect_pc = '0;
    i_stall = 1'b0;
    imem.ready = 1'b1;
    fork
      responder();
      sb_monitor();
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req", imem.req, 1'b0);
    check("rst_addr", imem.addr, RESET_ADDR);
    check("rst_valid", o_valid, 1'b0);
    check("rst_instr", o_instruction, NOP);
    check("rst_pc", o_pc, RESET_ADDR);
    check("rst_pc4", o_pc_plus4, 32'h4);
    check("rst_trap", o_fetch_trap, 1'b0);
    check("rst_squash", o_dbg_squash, 1'b0);
    check("rst_state", o_dbg_state, BOOT);
    @(posedge clk); #1 rst = 1'b0;

    // Sequential fetch, then redirect while the 0x8 response is still owed
    wait_accept("acc_0", 32'h0);
    wait_accept("acc_4", 32'h4);
    @(posedge clk); #1 mem_lat = 1;
    wait_accept("acc_8", 32'h8);
    @(posedge clk); #1;
    i_redirect = 1'b1;
    i_redirect_pc = 32'h100;
    @(posedge clk); #1 i_redirect = 1'b0;
    @(negedge clk);
    check("sq_state", o_dbg_state, WAIT);
    check("sq_squash", o_dbg_squash, 1'b1);
    check("sq_valid", o_valid, 1'b0);
    check("sq_req", imem.req, 1'b0);
    @(posedge clk); #1 mem_lat = 0;
    wait_valid("sq_first_pc", 32'h100);
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_valid) break;
    end
    check("valid_spacing", k + 1, 2);
    check("next_pc", o_pc, 32'h104);

    // Redirect in the same cycle as a response
    wait_accept("acc_10c", 32'h10C);
    @(posedge clk); #1;
    i_redirect = 1'b1;
    i_redirect_pc = 32'h200;
    @(posedge clk); #1 i_redirect = 1'b0;
    @(negedge clk);
    check("coinc_valid", o_valid, 1'b0);
    check("coinc_req", imem.req, 1'b1);
    check("coinc_addr", imem.addr, 32'h200);

    // Stall while a response returns: skid entry, HOLD, no new request
    wait_valid("stall_first_pc", 32'h200);
    @(posedge clk); #1 i_stall = 1'b1;
    hold_cycles = 0;
    req_in_hold = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_dbg_state == HOLD) begin
        hold_cycles++;
        if (imem.req) req_in_hold++;
      end
    end
    check("hold_cycles", hold_cycles, 3);
    check("hold_no_req", req_in_hold, 0);
    check("hold_slot_pc", o_pc, 32'h204);
    @(posedge clk); #1 i_stall = 1'b0;
    @(negedge clk);
    check("drain_state", o_dbg_state, HOLD);
    @(negedge clk);
    check("skid_state", o_dbg_state, REQ);
    check("skid_valid", o_valid, 1'b1);
    check("skid_pc", o_pc, 32'h208);

    // Table-driven redirects with memory not accepting
    @(posedge clk); #1 imem.ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      i_redirect = 1'b1;
      i_redirect_pc = tbl[i].target;
      @(posedge clk); #1 i_redirect = 1'b0;
      @(negedge clk);
      check("tbl_req", imem.req, tbl[i].req);
      if (tbl[i].req) check("tbl_addr", imem.addr, tbl[i].target);
      check("tbl_valid", o_valid, tbl[i].valid);
      check("tbl_trap", o_fetch_trap, tbl[i].trap);
      if (tbl[i].valid) begin
        check("tbl_pc", o_pc, tbl[i].target);
        check("tbl_instr", o_instruction, NOP);
        check("tbl_pc4", o_pc_plus4, tbl[i].pc4);
      end
      @(negedge clk);
      check("tbl_req2", imem.req, tbl[i].req);
      @(posedge clk); #1;
    end

    // PC wrap from the last table entry (0xFFFF_FFFC)
    imem.ready = 1'b1;
    wait_accept("wrap_acc_top", 32'hFFFF_FFFC);
    wait_accept("wrap_acc_zero", 32'h0);
    check("wrap_valid", o_valid, 1'b1);
    check("wrap_pc", o_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", o_pc_plus4, 32'h0);

    // Asynchronous reset in the middle of WAIT
    @(posedge clk); #1 mem_lat = 2;
    wait_accept("mid_acc", 32'h4);
    @(posedge clk); #3;
    check("mid_pre_state", o_dbg_state, WAIT);
    rst = 1'b1;
    #1;
    check("mid_req", imem.req, 1'b0);
    check("mid_addr", imem.addr, RESET_ADDR);
    check("mid_valid", o_valid, 1'b0);
    check("mid_instr", o_instruction, NOP);
    check("mid_pc", o_pc, RESET_ADDR);
    check("mid_pc4", o_pc_plus4, 32'h4);
    check("mid_trap", o_fetch_trap, 1'b0);
    check("mid_state", o_dbg_state, BOOT);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    mem_lat = 0;
    wait_accept("post_rst_acc", RESET_ADDR);
    wait_valid("post_rst_pc", RESET_ADDR);
    repeat (4) @(negedge clk);
    check("sb_pops_min", (n_pops >= 10), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
